// File: rtl/divider_pkg.sv
// Shared definitions for the execute-stage divider; the multiplier and EXU mux reuse them.
package divider_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned WLEN = 32;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StSpecial
    } div_state_e;

endpackage

// File: rtl/divider_if.sv
// Valid/ready/flush handshake between the EXU (master) and the divider (slave).
interface divider_if #(
    parameter int unsigned XLEN = divider_pkg::XLEN
);
    logic            flush;
    logic            div_valid;
    logic            divw;
    logic            div_signed;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            div_ready;
    logic            out_valid;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;

    modport master (
        output flush, div_valid, divw, div_signed, dividend, divisor,
        input  div_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  flush, div_valid, divw, div_signed, dividend, divisor,
        output div_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/div_prep.sv
// Operand preparation: W-form extension, magnitudes, result signs and special-case results.
module div_prep #(
    parameter int unsigned XLEN = divider_pkg::XLEN
) (
    input  logic            i_divw,
    input  logic            i_signed,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_abs_dvd,
    output logic [XLEN-1:0] o_abs_dvs,
    output logic            o_q_neg,
    output logic            o_r_neg,
    output logic            o_special,
    output logic [XLEN-1:0] o_spec_q,
    output logic [XLEN-1:0] o_spec_r
);
    import divider_pkg::*;

    localparam int unsigned ExtW = XLEN - WLEN;

    function automatic logic [XLEN-1:0] ext_w(input logic [WLEN-1:0] v, input logic sgn);
        return {{ExtW{sgn & v[WLEN-1]}}, v};
    endfunction

    logic [XLEN-1:0] w_eff_a, w_eff_b, w_min;
    logic            w_sa, w_sb, w_div_zero, w_ovf;

    always_comb begin
        w_eff_a    = i_divw ? ext_w(i_dividend[WLEN-1:0], i_signed) : i_dividend;
        w_eff_b    = i_divw ? ext_w(i_divisor[WLEN-1:0], i_signed) : i_divisor;
        w_sa       = i_signed & w_eff_a[XLEN-1];
        w_sb       = i_signed & w_eff_b[XLEN-1];
        // Most-negative value of the effective width, as it appears after sign extension
        w_min      = i_divw ? {{(ExtW + 1){1'b1}}, {(WLEN - 1){1'b0}}}
                            : {1'b1, {(XLEN - 1){1'b0}}};
        w_div_zero = (w_eff_b == '0);
        w_ovf      = i_signed & (w_eff_a == w_min) & (w_eff_b == '1);
        o_abs_dvd  = w_sa ? ('0 - w_eff_a) : w_eff_a;
        o_abs_dvs  = w_sb ? ('0 - w_eff_b) : w_eff_b;
        o_q_neg    = w_sa ^ w_sb;
        o_r_neg    = w_sa;
        o_special  = w_div_zero | w_ovf;
        o_spec_q   = w_div_zero ? '1 : w_eff_a;
        // W-form results are always sign-extended from bit 31, even for REMUW
        o_spec_r   = w_div_zero ? (i_divw ? ext_w(i_dividend[WLEN-1:0], 1'b1) : w_eff_a) : '0;
    end

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
module divider #(
    parameter int unsigned XLEN = divider_pkg::XLEN
) (
    input  logic      clk,
    input  logic      rst,
    divider_if.slave  bus
);
    import divider_pkg::*;

    localparam int unsigned CntW = $clog2(XLEN);

    div_state_e      r_state, w_state_nxt;
    logic            r_ready, w_ready_nxt, r_valid, w_valid_nxt;
    logic            r_q_neg, w_q_neg_nxt, r_r_neg, w_r_neg_nxt, r_divw, w_divw_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic [XLEN-1:0] r_quo, w_quo_nxt, r_rem, w_rem_nxt, r_dvd, w_dvd_nxt, r_dvs, w_dvs_nxt;
    logic [XLEN-1:0] r_quotient, w_quotient_nxt, r_remainder, w_remainder_nxt;

    logic [XLEN-1:0] w_abs_dvd, w_abs_dvs, w_spec_q, w_spec_r, w_q_fix, w_r_fix;
    logic            w_q_neg, w_r_neg, w_special, w_accept, w_fit;
    logic [XLEN:0]   w_shift, w_trial;

    div_prep #(.XLEN(XLEN)) u_prep (
        .i_divw     (bus.divw),
        .i_signed   (bus.div_signed),
        .i_dividend (bus.dividend),
        .i_divisor  (bus.divisor),
        .o_abs_dvd  (w_abs_dvd),
        .o_abs_dvs  (w_abs_dvs),
        .o_q_neg    (w_q_neg),
        .o_r_neg    (w_r_neg),
        .o_special  (w_special),
        .o_spec_q   (w_spec_q),
        .o_spec_r   (w_spec_r)
    );

    assign w_accept = bus.div_valid & r_ready;
    assign w_shift  = {r_rem, r_dvd[XLEN-1]};
    assign w_trial  = w_shift - {1'b0, r_dvs};
    assign w_fit    = ~w_trial[XLEN];
    assign w_q_fix  = r_q_neg ? ('0 - r_quo) : r_quo;
    assign w_r_fix  = r_r_neg ? ('0 - r_rem) : r_rem;

    always_comb begin
        w_state_nxt     = r_state;
        w_ready_nxt     = r_ready;
        w_valid_nxt     = r_valid;
        w_q_neg_nxt     = r_q_neg;
        w_r_neg_nxt     = r_r_neg;
        w_divw_nxt      = r_divw;
        w_cnt_nxt       = r_cnt;
        w_quo_nxt       = r_quo;
        w_rem_nxt       = r_rem;
        w_dvd_nxt       = r_dvd;
        w_dvs_nxt       = r_dvs;
        w_quotient_nxt  = r_quotient;
        w_remainder_nxt = r_remainder;
        unique case (r_state)
            StIdle: begin
                w_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_ready_nxt = 1'b0;
                    w_valid_nxt = 1'b0;
                    w_q_neg_nxt = w_q_neg;
                    w_r_neg_nxt = w_r_neg;
                    w_divw_nxt  = bus.divw;
                    w_dvs_nxt   = w_abs_dvs;
                    if (w_special) begin
                        w_quo_nxt   = w_spec_q;
                        w_rem_nxt   = w_spec_r;
                        w_state_nxt = StSpecial;
                    end else begin
                        // W operands are pre-aligned to the top so the iteration always
                        // consumes the dividend MSB
                        w_dvd_nxt   = bus.divw ? (w_abs_dvd << WLEN) : w_abs_dvd;
                        w_quo_nxt   = '0;
                        w_rem_nxt   = '0;
                        w_cnt_nxt   = bus.divw ? CntW'(WLEN - 1) : CntW'(XLEN - 1);
                        w_state_nxt = StCalc;
                    end
                end
            end
            StCalc: begin
                w_rem_nxt = w_fit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
                w_quo_nxt = {r_quo[XLEN-2:0], w_fit};
                w_dvd_nxt = {r_dvd[XLEN-2:0], 1'b0};
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = StFix;
                end
            end
            StFix: begin
                w_quotient_nxt  = r_divw ? {{(XLEN - WLEN){w_q_fix[WLEN-1]}}, w_q_fix[WLEN-1:0]}
                                         : w_q_fix;
                w_remainder_nxt = r_divw ? {{(XLEN - WLEN){w_r_fix[WLEN-1]}}, w_r_fix[WLEN-1:0]}
                                         : w_r_fix;
                w_valid_nxt     = 1'b1;
                w_ready_nxt     = 1'b1;
                w_state_nxt     = StIdle;
            end
            StSpecial: begin
                w_quotient_nxt  = r_quo;
                w_remainder_nxt = r_rem;
                w_valid_nxt     = 1'b1;
                w_ready_nxt     = 1'b1;
                w_state_nxt     = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
        // Flush drops any operation, including one being accepted this cycle
        if (bus.flush) begin
            w_state_nxt     = StIdle;
            w_ready_nxt     = 1'b1;
            w_valid_nxt     = 1'b0;
            w_quotient_nxt  = r_quotient;
            w_remainder_nxt = r_remainder;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_ready     <= 1'b0;
            r_valid     <= 1'b0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_divw      <= 1'b0;
            r_cnt       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= w_ready_nxt;
            r_valid     <= w_valid_nxt;
            r_q_neg     <= w_q_neg_nxt;
            r_r_neg     <= w_r_neg_nxt;
            r_divw      <= w_divw_nxt;
            r_cnt       <= w_cnt_nxt;
            r_quo       <= w_quo_nxt;
            r_rem       <= w_rem_nxt;
            r_dvd       <= w_dvd_nxt;
            r_dvs       <= w_dvs_nxt;
            r_quotient  <= w_quotient_nxt;
            r_remainder <= w_remainder_nxt;
        end
    end

    assign bus.div_ready = r_ready;
    assign bus.out_valid = r_valid;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: reference results come from native SV division.
module tb_divider;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    divider_if bus ();

    divider u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic [63:0] lat;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [63:0] last_q   = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic w, input logic s, input logic [63:0] a,
                                   input logic [63:0] b);
        exp_t               e;
        logic signed [31:0] a32, b32;
        logic signed [63:0] a64, b64;
        logic        [31:0] q32, r32;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            e.lat = 64'd33;
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a[31:0]; e.lat = 64'd1;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a[31:0]; r32 = 32'd0; e.lat = 64'd1;
            end else if (s) begin
                q32 = a32 / b32; r32 = a32 % b32;
            end else begin
                q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
            end
            e.q = {{32{q32[31]}}, q32};
            e.r = {{32{r32[31]}}, r32};
        end else begin
            a64 = a;
            b64 = b;
            e.lat = 64'd65;
            if (b == 64'd0) begin
                e.q = '1; e.r = a; e.lat = 64'd1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                e.q = a; e.r = '0; e.lat = 64'd1;
            end else if (s) begin
                e.q = a64 / b64; e.r = a64 % b64;
            end else begin
                e.q = a / b; e.r = a % b;
            end
        end
        return e;
    endfunction

    task automatic issue(input logic w, input logic s, input logic [63:0] a,
                         input logic [63:0] b, input logic push);
        logic acc = 1'b0;
        int   i   = 0;
        if (push) sb_q.push_back(model(w, s, a, b));
        bus.divw       = w;
        bus.div_signed = s;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.div_valid  = 1'b1;
        while (!acc && i < 300) begin
            acc = bus.div_ready;
            @(posedge clk);
            #1;
            i++;
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        bus.div_valid = 1'b0;
        // Scramble operands to show they are only sampled at accept
        bus.dividend  = {$urandom, $urandom};
        bus.divisor   = {$urandom, $urandom};
        bus.divw      = 1'($urandom);
        check("valid_clr", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic collect(input string tag);
        int unsigned cyc = 0;
        exp_t        e;
        while (!bus.out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_q"}, bus.quotient, e.q);
            check({tag, "_r"}, bus.remainder, e.r);
            check({tag, "_lat"}, 64'(cyc), e.lat);
            last_q = e.q;
        end
    endtask

    initial begin
        bus.flush      = 1'b0;
        bus.div_valid  = 1'b0;
        bus.divw       = 1'b0;
        bus.div_signed = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.div_ready), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_q", bus.quotient, 64'd0);
        check("rst_r", bus.remainder, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", 64'(bus.div_ready), 64'd1);

        issue(1'b0, 1'b0, 64'd100, 64'd7, 1'b1);                          collect("u64");
        issue(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);          collect("s64_neg_dvd");
        issue(1'b0, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);          collect("s64_neg_dvs");
        issue(1'b0, 1'b0, 64'h1234, 64'd0, 1'b1);                         collect("dz64");
        issue(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 1'b1);  collect("ovf_w");
        issue(1'b1, 1'b0, 64'hFFFF_FFFF, 64'd1, 1'b1);                    collect("divuw");
        issue(1'b0, 1'b1, 64'h8000_0000_0000_0000, '1, 1'b1);             collect("ovf64");
        issue(1'b1, 1'b0, 64'h5555_5555_8000_0001, 64'hABCD_0000_0000_0000, 1'b1);
        collect("dz_remuw");

        // Abort a 64-bit op at cycle 20
        issue(1'b0, 1'b0, 64'hDEAD_BEEF_0000_1234, 64'd3, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_ready", 64'(bus.div_ready), 64'd1);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_q_hold", bus.quotient, last_q);
        issue(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FC18, 64'd3, 1'b1);          collect("post_flush");

        // Flush beats a simultaneous accept
        bus.dividend  = 64'd50;
        bus.divisor   = 64'd5;
        bus.divw      = 1'b0;
        bus.flush     = 1'b1;
        bus.div_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.div_valid = 1'b0;
        check("flush_acc_ready", 64'(bus.div_ready), 64'd1);
        check("flush_acc_valid", 64'(bus.out_valid), 64'd0);

        // Second op held valid while the first is busy
        issue(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 1'b1);
        bus.divw       = 1'b1;
        bus.div_signed = 1'b1;
        bus.dividend   = 64'h0000_0000_FFFF_FF9C;
        bus.divisor    = 64'd7;
        bus.div_valid  = 1'b1;
        collect("held_a");
        issue(1'b1, 1'b1, 64'h0000_0000_FFFF_FF9C, 64'd7, 1'b1);          collect("held_b");

        for (int k = 0; k < 8; k++) begin
            logic        w, s;
            logic [63:0] a, b;
            w = 1'($urandom);
            s = 1'($urandom);
            a = {$urandom, $urandom};
            b = (k % 2 == 0) ? {32'd0, $urandom} : {$urandom, $urandom};
            issue(w, s, a, b, 1'b1);
            collect("rand");
        end

        // Reset in the middle of an operation
        issue(1'b0, 1'b0, 64'd12345, 64'd6, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_ready", 64'(bus.div_ready), 64'd0);
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_q", bus.quotient, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_ready_up", 64'(bus.div_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
